// File: rtl/port_out_f_if.sv
// Core-write / consumer-read bundle for the output-port FIFO.
// The slave modport belongs to the buffer; the master modport is the core and consumer side.
interface port_out_f_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] wdata;
  logic             en;
  logic             clr_ovf;
  logic [WIDTH-1:0] port;
  logic             valid;
  logic             ready;
  logic             full;
  logic [CW-1:0]    count;
  logic             ovf;

  modport slave (
    input  wdata, en, clr_ovf, ready,
    output port, valid, full, count, ovf
  );

  modport master (
    output wdata, en, clr_ovf, ready,
    input  port, valid, full, count, ovf
  );
endinterface

// File: rtl/port_out_f.sv
// Output-port buffer: single-cycle core writes are queued in a small FIFO and
// presented over VALID/READY; writes that arrive while full are dropped and flagged.
module port_out_f #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  port_out_f_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    count;
  logic             ovf;

  logic valid;
  logic full;
  logic push;
  logic pop;
  logic drop;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  // FULL comes from the pre-edge count, so a same-cycle pop never frees room for a push.
  assign push  = bus.en & ~full;
  assign drop  = bus.en & full;
  assign pop   = valid & bus.ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (drop) begin
        ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  assign bus.port  = valid ? mem[rp] : '0;
  assign bus.valid = valid;
  assign bus.full  = full;
  assign bus.count = count;
  assign bus.ovf   = ovf;
endmodule

// File: tb/tb_port_out_f.sv
// Directed bench for port_out_f: reset, fill/drain order, overflow, streaming wrap,
// back-pressure and reset mid-operation, with hand-computed expectations.
module tb_port_out_f;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  port_out_f_if #(.WIDTH(8), .DEPTH(4)) bus ();

  port_out_f #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] port, input logic valid,
                           input logic full, input logic [2:0] count, input logic ovf);
    chk({tag, ".port"},  32'(bus.port),  32'(port));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(valid));
    chk({tag, ".full"},  32'(bus.full),  32'(full));
    chk({tag, ".count"}, 32'(bus.count), 32'(count));
    chk({tag, ".ovf"},   32'(bus.ovf),   32'(ovf));
  endtask

  logic [7:0] fill_v  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] drain_v [4] = '{8'h22, 8'h33, 8'h44, 8'hBB};

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.wdata = '0;
    bus.en = 1'b0;
    bus.clr_ovf = 1'b0;
    bus.ready = 1'b0;
    step();
    step();
    chk_state("reset", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;

    // idle with READY held high
    bus.ready = 1'b1;
    step();
    step();
    chk_state("idle", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

    // fill with READY low
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wdata = fill_v[i];
      bus.en = 1'b1;
      step();
      chk($sformatf("fill%0d.count", i), 32'(bus.count), i + 1);
      chk($sformatf("fill%0d.port", i), 32'(bus.port), 32'h11);
    end
    bus.en = 1'b0;
    chk_state("full", 8'h11, 1'b1, 1'b1, 3'd4, 1'b0);

    // drop while full, no pop
    bus.wdata = 8'hAA;
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    chk_state("drop_nopop", 8'h11, 1'b1, 1'b1, 3'd4, 1'b1);

    // drop while full with a pop in the same cycle
    bus.en = 1'b1;
    bus.ready = 1'b1;
    step();
    bus.en = 1'b0;
    bus.ready = 1'b0;
    chk_state("drop_pop", 8'h22, 1'b1, 1'b0, 3'd3, 1'b1);

    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    chk("clr.ovf", 32'(bus.ovf), 0);

    bus.wdata = 8'hBB;
    bus.en = 1'b1;
    step();
    chk_state("refill", 8'h22, 1'b1, 1'b1, 3'd4, 1'b0);

    // clear and drop together: set wins
    bus.wdata = 8'hCC;
    bus.clr_ovf = 1'b1;
    step();
    bus.en = 1'b0;
    bus.clr_ovf = 1'b0;
    chk_state("clr_drop", 8'h22, 1'b1, 1'b1, 3'd4, 1'b1);

    bus.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d.port", i), 32'(bus.port), 32'(drain_v[i]));
      step();
      chk($sformatf("drain%0d.full", i), 32'(bus.full), 0);
    end
    chk_state("drained", 8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;

    // streaming with pointer wrap
    for (int i = 0; i < 16; i++) begin
      bus.wdata = 8'(i);
      bus.en = 1'b1;
      step();
      chk($sformatf("stream%0d.port", i), 32'(bus.port), i);
      chk($sformatf("stream%0d.count", i), 32'(bus.count), 1);
    end
    bus.en = 1'b0;
    step();
    chk_state("stream_end", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

    // back-pressure
    bus.ready = 1'b0;
    bus.en = 1'b1;
    bus.wdata = 8'h50;
    step();
    bus.wdata = 8'h51;
    step();
    chk_state("bp_pre", 8'h50, 1'b1, 1'b0, 3'd2, 1'b0);
    bus.wdata = 8'h52;
    bus.ready = 1'b1;
    step();
    chk_state("bp_r1", 8'h51, 1'b1, 1'b0, 3'd2, 1'b0);
    bus.wdata = 8'h53;
    bus.ready = 1'b0;
    step();
    chk_state("bp_r0", 8'h51, 1'b1, 1'b0, 3'd3, 1'b0);
    bus.wdata = 8'h54;
    bus.ready = 1'b1;
    step();
    chk_state("bp_r1b", 8'h52, 1'b1, 1'b0, 3'd3, 1'b0);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_drain%0d.port", i), 32'(bus.port), 32'h52 + i);
      step();
    end
    chk_state("bp_end", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

    // reset mid-operation
    bus.ready = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wdata = 8'h61 + 8'(i);
      step();
    end
    bus.en = 1'b0;
    chk_state("pre_rst", 8'h61, 1'b1, 1'b0, 3'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    rst_n = 1'b1;
    bus.wdata = 8'h5A;
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    chk_state("post_rst", 8'h5A, 1'b1, 1'b0, 3'd1, 1'b0);
    bus.ready = 1'b1;
    step();
    chk_state("post_rst_pop", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/port_out_f.md
# port_out_f

Output-port buffer for the one-cycle CPU: the outbound counterpart of the register file's sampled input port. The core writes bytes with a single-cycle enable; the block queues them in a small FIFO and presents them to an external consumer over a VALID/READY handshake. A sticky overflow flag records writes dropped while the queue was full.

## Interface
- WIDTH, 8, data width of the CPU write bus and the external port
- DEPTH, 4, number of FIFO entries; power of two, at least 2
- CLK  in  1  system clock; all state changes on its rising edge
- RST_N  in  1  reset, asynchronous and active-low
- IN  in  WIDTH  write data from the core
- EN  in  1  write strobe; one entry per cycle while high
- CLR_OVF  in  1  synchronous clear of OVF
- PORT  out  WIDTH  head-of-queue data to the external device; 0 when VALID=0
- VALID  out  1  queue non-empty; PORT holds a valid entry
- READY  in  1  external consumer accepts PORT this cycle
- FULL  out  1  COUNT == DEPTH
- COUNT  out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH
- OVF  out  1  sticky: at least one write was dropped

## Operation
- Storage: DEPTH x WIDTH array. Write pointer WP and read pointer RP are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. COUNT is a separate registered counter.
- Push: when EN=1 and FULL=0, write IN to mem[WP] and advance WP.
- Pop: when VALID=1 and READY=1, advance RP.
- Count: COUNT += push - pop. Simultaneous push and pop leaves COUNT unchanged.
- Drop: when EN=1 and FULL=1, the write is discarded and OVF is set. This applies even if a pop happens in the same cycle. FULL is evaluated from the pre-edge COUNT, with no pass-through.
- Empty: READY is ignored when VALID=0. No pointer moves and COUNT does not underflow.
- Outputs:
  - PORT = VALID ? mem[RP] : 0. This is combinational from registered state, with no combinational path from IN, EN or READY.
  - VALID = (COUNT != 0).
  - FULL = (COUNT == DEPTH).
- OVF: CLR_OVF=1 clears OVF. If a drop occurs in the same cycle, setting wins and OVF stays 1.
- Reset (RST_N=0, async): WP=0, RP=0, COUNT=0, OVF=0. Therefore VALID=0, FULL=0 and PORT=0 immediately. The mem contents are not reset.
- Reset mid-transfer: all queued entries are lost. No handshake completes in a cycle where RST_N is low at the rising edge.
- Handshake rules:
  - The consumer may hold READY high continuously.
  - PORT and VALID stay stable until the pop edge. Once VALID=1, it does not drop without a pop.

## Timing
- Write-to-visible latency is 1 cycle. With EN=1 at edge N into an empty queue, VALID=1 and PORT=IN after edge N.
- Throughput: 1 push and 1 pop per cycle sustained. With READY held at 1 and EN=1 every cycle, COUNT stays at 1.
- Pop takes effect at the rising edge where VALID&READY=1. The next entry, or 0 if the queue is now empty, appears after that edge.
- FULL asserts the cycle after the DEPTH-th push with no pop. It deasserts the cycle after the first pop.
- Reset assertion is asynchronous. Deassertion is expected to be synchronized externally; the first push is accepted at the first edge with RST_N=1.

## Test plan
- Reset/idle: assert RST_N=0 mid-cycle -> PORT=0, VALID=0, FULL=0, COUNT=0, OVF=0 immediately. Hold READY=1 with no EN -> no change.
- Fill and drain order: with READY=0, push 8'h11, 8'h22, 8'h33, 8'h44 -> COUNT=4, FULL=1, PORT=8'h11. Raise READY -> PORT reads 11, 22, 33, 44 on successive cycles, then VALID=0 and PORT=0.
- Overflow:
  - With the queue full and READY=0, push 8'hAA -> dropped, OVF=1, COUNT=4, contents unchanged.
  - Repeat with READY=1 in the same cycle -> still dropped, COUNT=3.
  - Then CLR_OVF=1 -> OVF=0. CLR_OVF together with a drop -> OVF stays 1.
- Streaming and wrap: with READY=1, push 8'h00..8'h0F, one per cycle -> each value appears on PORT one cycle after its push, in order, with COUNT=1 throughout. Both pointers wrap 4 times with no loss.
- Back-pressure: with COUNT=2, toggle READY 1,0,1 while pushing every cycle -> COUNT goes 2,3,3. PORT holds steady during READY=0. No duplicates or skips.
- Reset mid-operation: with COUNT=3, pull RST_N low -> VALID=0 and COUNT=0 immediately. After release, push 8'h5A -> PORT=8'h5A and COUNT=1; no stale data is seen.
